// File: rtl/scr1_dp_tcm_ram.sv
// Dual-port TCM RAM: port A read-only fetch, port B byte-write data.
// Zero-fill after reset, optional output register and B->A forwarding.
module scr1_dp_tcm_ram #(
    parameter int SCR1_WIDTH     = 32,
    parameter int SCR1_SIZE      = 65536,
    localparam int SCR1_NBYTES   = SCR1_WIDTH / 8,
    parameter int OUT_REG        = 0,
    parameter int INIT_ZERO      = 1,
    parameter int FWD_EN         = 1,
    localparam int AW            = $clog2(SCR1_SIZE) - 2,
    localparam int DEPTH         = SCR1_SIZE / SCR1_NBYTES
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic                   init_done,
    input  logic                   rena,
    input  logic [AW-1:0]          addra,
    output logic [SCR1_WIDTH-1:0]  qa,
    output logic                   qa_vld,
    input  logic                   renb,
    input  logic                   wenb,
    input  logic [SCR1_NBYTES-1:0] webb,
    input  logic [AW-1:0]          addrb,
    input  logic [SCR1_WIDTH-1:0]  datab,
    output logic [SCR1_WIDTH-1:0]  qb,
    output logic                   qb_vld
);

    typedef enum logic {
        ST_INIT,
        ST_READY
    } state_t;

    localparam logic [AW:0] LAST = (AW+1)'(DEPTH - 1);

    state_t                  state;
    logic [AW:0]             ptr;
    logic [SCR1_WIDTH-1:0]   mem [DEPTH];
    logic [SCR1_NBYTES-1:0]  be;
    logic                    acc;
    logic [SCR1_WIDTH-1:0]   old_a;
    logic [SCR1_WIDTH-1:0]   old_b;
    logic [SCR1_WIDTH-1:0]   new_b;
    logic [SCR1_WIDTH-1:0]   rd_a;
    logic                    a1_vld;
    logic                    b1_vld;
    logic [SCR1_WIDTH-1:0]   a1_q;
    logic [SCR1_WIDTH-1:0]   b1_q;

    assign acc   = (state == ST_READY);
    assign be    = webb & {SCR1_NBYTES{wenb & acc}};
    assign old_a = mem[addra];
    assign old_b = mem[addrb];

    // Merge write data into the current word byte by byte
    always_comb begin
        new_b = old_b;
        for (int i = 0; i < SCR1_NBYTES; i++) begin
            if (be[i]) new_b[8*i +: 8] = datab[8*i +: 8];
        end
    end

    // Port A sees the post-write word only when forwarding is enabled
    always_comb begin
        rd_a = old_a;
        if (FWD_EN != 0 && (|be) && addra == addrb) rd_a = new_b;
    end

    // Array write: zero-fill pointer during init, byte writes afterwards
    always_ff @(posedge clk) begin
        if (state == ST_INIT) begin
            mem[ptr[AW-1:0]] <= '0;
        end else if (|be) begin
            mem[addrb] <= new_b;
        end
    end

    // Init sequencer: walk every word once, then stay ready until reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= (INIT_ZERO != 0) ? ST_INIT : ST_READY;
            ptr       <= '0;
            init_done <= (INIT_ZERO == 0);
        end else begin
            unique case (state)
                ST_INIT: begin
                    if (ptr == LAST) begin
                        state     <= ST_READY;
                        init_done <= 1'b1;
                    end else begin
                        ptr <= ptr + 1'b1;
                    end
                end
                ST_READY: begin
                    init_done <= 1'b1;
                end
                default: state <= ST_INIT;
            endcase
        end
    end

    // First read stage: capture data only when a read is accepted
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a1_vld <= 1'b0;
            b1_vld <= 1'b0;
            a1_q   <= '0;
            b1_q   <= '0;
        end else begin
            a1_vld <= rena & acc;
            b1_vld <= renb & acc;
            if (rena && acc) a1_q <= rd_a;
            if (renb && acc) b1_q <= new_b;
        end
    end

    generate
        if (OUT_REG != 0) begin : g_oreg
            // Second stage advances every cycle; data held when not valid
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    qa_vld <= 1'b0;
                    qb_vld <= 1'b0;
                    qa     <= '0;
                    qb     <= '0;
                end else begin
                    qa_vld <= a1_vld;
                    qb_vld <= b1_vld;
                    if (a1_vld) qa <= a1_q;
                    if (b1_vld) qb <= b1_q;
                end
            end
        end else begin : g_noreg
            assign qa_vld = a1_vld;
            assign qb_vld = b1_vld;
            assign qa     = a1_q;
            assign qb     = b1_q;
        end
    endgenerate

endmodule
